// File: rtl/booth_r4_seq_ctrl.sv
// Sequential radix-4 Booth multiplier: BITS/2 recode steps, one sign-magnitude
// conversion cycle, then the result is held until the consumer takes it.
module booth_r4_seq_ctrl #(
   parameter int BITS = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BITS-1:0]     a,
   input  logic [BITS-1:0]     b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*BITS-1:0]   product,
   output logic [2*BITS-1:0]   product_sm,
   output logic                busy,
   output logic [1:0]          dbg_state
);
   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; ready never depends combinationally on the partner's valid.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_CONV = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int AW    = 2*BITS + 2;
   localparam int PW    = 2*BITS;
   localparam int STEPS = BITS/2;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   state_t            state_q, state_d;
   logic [AW-1:0]     acc_q, acc_d;
   logic [AW-1:0]     mcand_q, mcand_d;
   logic [BITS:0]     mplr_q, mplr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]     prod_q, prod_d;
   logic [PW-1:0]     sm_q, sm_d;
   logic [AW-1:0]     pp;
   logic [PW-2:0]     neg_mag;

   // Multiplicand is pre-shifted by 4^i and the multiplier shifted down, so the
   // current Booth triplet is always mplr_q[2:0] (with b[-1] = 0 appended).
   always_comb begin
      pp = '0;
      case (mplr_q[2:0])
         3'b001, 3'b010: pp = mcand_q;
         3'b011:         pp = {mcand_q[AW-2:0], 1'b0};
         3'b100:         pp = ~{mcand_q[AW-2:0], 1'b0} + AW'(1);
         3'b101, 3'b110: pp = ~mcand_q + AW'(1);
         default:        pp = '0;
      endcase
   end

   assign neg_mag = ~acc_q[PW-2:0] + (PW-1)'(1);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      sm_d    = sm_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_CALC;
               acc_d   = '0;
               cnt_d   = '0;
               mcand_d = {{(AW-BITS){a[BITS-1]}}, a};
               mplr_d  = {b, 1'b0};
            end
         end
         S_CALC: begin
            acc_d   = acc_q + pp;
            mcand_d = mcand_q << 2;
            mplr_d  = {2'b00, mplr_q[BITS:2]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(STEPS-1)) state_d = S_CONV;
         end
         S_CONV: begin
            prod_d  = acc_q[PW-1:0];
            sm_d    = {acc_q[PW-1], acc_q[PW-1] ? neg_mag : acc_q[PW-2:0]};
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
         sm_q    <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         sm_q    <= sm_d;
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign product    = prod_q;
   assign product_sm = sm_q;
   assign dbg_state  = state_q;
endmodule

// File: tb/tb_booth_r4_seq_ctrl.sv
// Directed bench for booth_r4_seq_ctrl (BITS=32) with hand-computed products.
module tb_booth_r4_seq_ctrl;
   localparam int BITS = 32;
   localparam int PW   = 64;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic [BITS-1:0] a = '0;
   logic [BITS-1:0] b = '0;
   logic            in_ready, out_valid, busy;
   logic [PW-1:0]   product, product_sm;
   logic [1:0]      dbg_state;

   int errors = 0;
   int checks = 0;

   booth_r4_seq_ctrl #(.BITS(BITS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .product_sm(product_sm), .busy(busy),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Driver: present operands and hold in_valid until the accept edge.
   task automatic drive_accept(input logic [BITS-1:0] aa, input logic [BITS-1:0] bb);
      a = aa; b = bb; in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (in_ready) begin
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   // Counts edges until out_valid; a budget overrun returns the budget value.
   task automatic wait_out_valid(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset;
      #2;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (product !== 64'h0) begin errors++; $display("FAIL reset_product got=%h exp=0", product); end
      checks++; if (product_sm !== 64'h0) begin errors++; $display("FAIL reset_product_sm got=%h exp=0", product_sm); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mult(input string name, input logic [BITS-1:0] aa, input logic [BITS-1:0] bb,
                            input logic [PW-1:0] exp_p, input logic [PW-1:0] exp_sm);
      int cyc;
      drive_accept(aa, bb);
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL %s_accept busy=%b in_ready=%b exp busy=1 in_ready=0", name, busy, in_ready); end
      wait_out_valid(cyc);
      checks++; if (cyc !== 17) begin errors++; $display("FAIL %s_latency got=%0d exp=17", name, cyc); end
      checks++; if (product !== exp_p) begin errors++; $display("FAIL %s_product got=%h exp=%h", name, product, exp_p); end
      checks++; if (product_sm !== exp_sm) begin errors++; $display("FAIL %s_product_sm got=%h exp=%h", name, product_sm, exp_sm); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL %s_release out_valid=%b in_ready=%b busy=%b exp 0/1/0", name, out_valid, in_ready, busy); end
      checks++; if (product !== exp_p || product_sm !== exp_sm) begin errors++; $display("FAIL %s_hold got=%h/%h exp=%h/%h", name, product, product_sm, exp_p, exp_sm); end
   endtask

   task automatic test_backpressure;
      int cyc;
      drive_accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_out_valid(cyc);
      checks++; if (cyc !== 17) begin errors++; $display("FAIL bp_latency got=%0d exp=17", cyc); end
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin a = 32'd5; b = 32'd5; in_valid = 1'b1; end
         else in_valid = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (product !== 64'h1 || product_sm !== 64'h1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold_%0d product=%h sm=%h in_ready=%b out_valid=%b exp 1/1/0/1", i, product, product_sm, in_ready, out_valid);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1 || dbg_state !== 2'd0) begin errors++; $display("FAIL bp_idle in_ready=%b state=%0d exp 1/0", in_ready, dbg_state); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || product !== 64'h1) begin errors++; $display("FAIL bp_ignored busy=%b product=%h exp 0/1", busy, product); end
   endtask

   task automatic test_reset_mid;
      drive_accept(32'h0000_1234, 32'h0000_5678);
      repeat (7) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl busy=%b in_ready=%b out_valid=%b exp 0/1/0", busy, in_ready, out_valid); end
      checks++; if (product !== 64'h0 || product_sm !== 64'h0) begin errors++; $display("FAIL rstmid_data product=%h sm=%h exp 0/0", product, product_sm); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_release in_ready=%b busy=%b exp 1/0", in_ready, busy); end
      test_mult("zero", 32'h0, 32'hFFFF_FFFB, 64'h0, 64'h0);
   endtask

   task automatic test_back_to_back;
      int n;
      int gap;
      bit saw_idle;
      a = 32'd3; b = 32'd4; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_first_accept busy=%b exp 1", busy); end
      a = 32'hFFFF_FFFE; b = 32'd6;
      n = 0; gap = -1; saw_idle = 1'b0;
      while (n < 60 && gap < 0) begin
         @(posedge clk); #1;
         n++;
         if (n == 17) begin
            checks++; if (product !== 64'd12 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first product=%h out_valid=%b exp 12/1", product, out_valid); end
         end
         if (in_ready) saw_idle = 1'b1;
         else if (saw_idle && busy) gap = n;
      end
      in_valid = 1'b0;
      checks++; if (gap !== 19) begin errors++; $display("FAIL b2b_spacing got=%0d exp=19", gap); end
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checks++; if (n !== 17) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=17", n); end
      checks++; if (product !== 64'hFFFF_FFFF_FFFF_FFF4) begin errors++; $display("FAIL b2b_second_product got=%h exp=fffffffffffffff4", product); end
      checks++; if (product_sm !== 64'h8000_0000_0000_000C) begin errors++; $display("FAIL b2b_second_sm got=%h exp=800000000000000c", product_sm); end
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_end in_ready=%b exp 1", in_ready); end
   endtask

   initial begin
      test_reset();
      test_mult("pos_neg", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64'h8000_0000_0000_0015);
      test_mult("min_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);
      test_mult("min_one", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 64'h8000_0000_8000_0000);
      test_mult("pos_pos", 32'd12345, 32'd6789, 64'd83810205, 64'd83810205);
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/booth_r4_seq_ctrl.md
# booth_r4_seq_ctrl

Sequential radix-4 Booth multiplier controller that owns the Booth partial-product datapath and sequences it over BITS/2 recode steps. It accepts two signed two's-complement operands over a valid/ready handshake and returns the full 2*BITS-bit product in two forms. The first form is the two's-complement product. The second is the sign-magnitude product from a dedicated conversion cycle. The block sits between the operand source and any consumer that needs either encoding. It is the single scheduler of the shared multiplier datapath.

## Interface
- BITS, 32, operand width; must be even and >= 4
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept an operand pair; high only in IDLE
- a  in  BITS  multiplicand, signed two's complement
- b  in  BITS  multiplier, signed two's complement; this operand is Booth-recoded
- out_valid  out  1  result registers valid
- out_ready  in  1  consumer takes the result
- product  out  2*BITS  a*b, two's complement
- product_sm  out  2*BITS  a*b, sign-magnitude: [2*BITS-1] is the sign, [2*BITS-2:0] is |a*b|
- busy  out  1  FSM not in IDLE

## Operation
- FSM states and transitions:
  - IDLE -> CALC when in_valid && in_ready.
  - CALC -> CONV after BITS/2 steps.
  - CONV -> DONE.
  - DONE -> IDLE when out_valid && out_ready.
- Accept edge: latch a and b; clear the accumulator; clear the step counter. After acceptance, changes on a, b and in_valid are ignored.
- CALC:
  - Step i (0..BITS/2-1) examines the triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - The step adds 0, ±A or ±2A, weighted by 4^i, to the accumulator.
  - A is sign-extended to 2*BITS+2 bits.
  - Step counter width is clog2(BITS/2). The step counter wraps only on the CALC exit.
- CONV:
  - product <= accumulator[2*BITS-1:0].
  - product_sm sign bit = product[2*BITS-1].
  - product_sm magnitude bits = the corresponding bits of the negated product if the product is negative, else the product bits unchanged.
  - The product is exact, and no overflow is possible. The maximum magnitude is 2^(2*BITS-2), at a = b = -2^(BITS-1). That magnitude fits in 2*BITS-1 bits.
  - Zero product gives sign 0.
- DONE: out_valid=1. product and product_sm are held stable until the output handshake.
- Output handshake edge: out_valid <= 0. product and product_sm keep their last values until the next CONV.
- Simultaneous events:
  - An input cannot be accepted on the output-handshake edge, because in_ready=0 in DONE.
  - in_valid during CALC, CONV or DONE is ignored, with no queuing.
- Reset:
  - Asserting rst_n at any time forces IDLE immediately and discards any in-flight operation.
  - Reset values: in_ready=1, out_valid=0, busy=0, product=0, product_sm=0, accumulator=0, step counter=0.

## Timing
- All state changes happen on the rising edge of clk, except reset, which is asynchronous.
- Accept at edge E0: busy=1 and in_ready=0 from E0.
- out_valid rises at edge E0+BITS/2+1, which is E17 for BITS=32. That interval is BITS/2 CALC edges plus 1 CONV edge.
- If out_ready is held high, the output handshake occurs at E0+BITS/2+2, and in_ready=1 after that edge.
- The next accept is possible at E0+BITS/2+3, so the maximum throughput is one operation per BITS/2+3 cycles.
- in_ready and busy are decoded from registered state only, with no combinational path from in_valid or out_ready.

## Test plan
- BITS=32, a=7, b=-3 (0xFFFFFFFD) -> after 17 cycles: product=0xFFFFFFFFFFFFFFEB, product_sm=0x8000000000000015.
- a=b=0x80000000 -> product=0x4000000000000000, product_sm=0x4000000000000000 (sign 0).
- a=0x80000000, b=1 -> product=0xFFFFFFFF80000000, product_sm=0x8000000080000000.
- Backpressure with a=-1, b=-1:
  - Hold out_ready=0 for 5 cycles after out_valid rises, and pulse in_valid with new operands during that time.
  - Required response: product=1 and product_sm=1 stay stable, in_ready=0, and the pulsed operands are ignored.
  - Then raise out_ready: IDLE is entered on the next edge.
- Reset mid-operation:
  - Assert rst_n low during the 8th CALC cycle.
  - Required response: all outputs return to reset values immediately, and in_ready=1 after release.
  - Then a=0, b=-5 -> product=0, product_sm=0.
- Back-to-back: hold in_valid=1 with (3,4) then (-2,6), and out_ready=1 -> product 12, then 0xFFFFFFFFFFFFFFF4 / sm 0x800000000000000C; accepts are spaced exactly 19 cycles apart.
